// File: rtl/const_bank.sv
// Constant and user-register bank feeding the pairing datapath operand mux.
// One-hot reads are decoded in stage 0 and then pass through LATENCY register stages.
module const_bank #(
    parameter int WIDTH   = 198,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              effective,
    output logic              wr_err
);

    localparam int NUM_USER = ADDR_W - 5;
    localparam int NUM_SLOT = (NUM_USER > 0) ? NUM_USER : 1;

    localparam logic [ADDR_W-1:0] USER_MASK = {ADDR_W{1'b1}} << 5;
    localparam logic [WIDTH-1:0]  C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0]  C_PLUS    = {6'b000101, {(WIDTH-6){1'b0}}};
    localparam logic [WIDTH-1:0]  C_MINUS   = {6'b001001, {(WIDTH-6){1'b0}}};
    localparam logic [WIDTH-1:0]  C_CUBIC   = {6'b010101, {(WIDTH-6){1'b0}}};

    function automatic logic is_onehot(input logic [ADDR_W-1:0] a);
        return (a != '0) && ((a & (a - ADDR_W'(1))) == '0);
    endfunction

    logic [WIDTH-1:0]   slot_q [NUM_SLOT];
    logic               wr_ok;
    logic               wr_err_q;
    logic [WIDTH-1:0]   rd_data_d;
    logic               rd_eff_d;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [LATENCY-1:0] eff_q;
    logic [LATENCY-1:0] vld_q;

    // Only a one-hot hit on a user slot may write; anything else is flagged.
    assign wr_ok = wr_en && is_onehot(wr_addr) && ((wr_addr & USER_MASK) != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SLOT; k++) slot_q[k] <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_ok;
            for (int k = 0; k < NUM_USER; k++) begin
                if (wr_ok && wr_addr[5+k]) slot_q[k] <= wr_data;
            end
        end
    end

    // Stage 0 decode; a same-edge write to the addressed slot is forwarded.
    always_comb begin
        rd_data_d = '0;
        rd_eff_d  = 1'b0;
        if (is_onehot(rd_addr)) begin
            rd_eff_d = 1'b1;
            if (rd_addr[1]) rd_data_d = C_ONE;
            if (rd_addr[2]) rd_data_d = C_PLUS;
            if (rd_addr[3]) rd_data_d = C_MINUS;
            if (rd_addr[4]) rd_data_d = C_CUBIC;
            for (int k = 0; k < NUM_USER; k++) begin
                if (rd_addr[5+k]) rd_data_d = (wr_ok && wr_addr[5+k]) ? wr_data : slot_q[k];
            end
        end
    end

    // out_valid is a pure strobe with no backpressure: it is high for exactly one cycle
    // per accepted read, LATENCY cycles after issue; out/effective hold across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            eff_q <= '0;
            for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                data_q[0] <= rd_data_d;
                eff_q[0]  <= rd_eff_d;
            end
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                    eff_q[i]  <= eff_q[i-1];
                end
            end
        end
    end

    assign out       = data_q[LATENCY-1];
    assign out_valid = vld_q[LATENCY-1];
    assign effective = eff_q[LATENCY-1];
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_const_bank.sv
// Directed bench for const_bank: one instance at LATENCY=1 and one at LATENCY=3,
// both driven by the same read/write stimulus.
module tb_const_bank;

    localparam int W = 198;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = '0;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;

    logic [W-1:0] out1, out3;
    logic         valid1, valid3, eff1, eff3, err1, err3;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] c_plus, c_minus, c_cubic;

    const_bank #(.WIDTH(W), .ADDR_W(8), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out1), .out_valid(valid1), .effective(eff1), .wr_err(err1)
    );

    const_bank #(.WIDTH(W), .ADDR_W(8), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out3), .out_valid(valid3), .effective(eff3), .wr_err(err3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (out1 !== '0)    begin errors++; $display("FAIL reset_out1: got %h expected 0", out1); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", valid1); end
        checks++; if (eff1 !== 1'b0)   begin errors++; $display("FAIL reset_eff1: got %b expected 0", eff1); end
        checks++; if (err1 !== 1'b0)   begin errors++; $display("FAIL reset_err1: got %b expected 0", err1); end
        checks++; if (out3 !== '0)    begin errors++; $display("FAIL reset_out3: got %h expected 0", out3); end
        checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL reset_valid3: got %b expected 0", valid3); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_constants();
        logic [7:0]   addrs [5];
        logic [W-1:0] exps  [5];
        addrs = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16};
        exps  = '{'0, W'(1), c_plus, c_minus, c_cubic};
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            rd_addr = addrs[i];
            step();
            checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL const_valid[%0d]: got %b expected 1", i, valid1); end
            checks++; if (eff1 !== 1'b1)   begin errors++; $display("FAIL const_eff[%0d]: got %b expected 1", i, eff1); end
            checks++; if (out1 !== exps[i]) begin errors++; $display("FAIL const_out[%0d]: got %h expected %h", i, out1, exps[i]); end
        end
        rd_en = 1'b0;
        step();
        checks++; if (valid1 !== 1'b0)   begin errors++; $display("FAIL const_bubble_valid: got %b expected 0", valid1); end
        checks++; if (out1 !== c_cubic) begin errors++; $display("FAIL const_bubble_hold: got %h expected %h", out1, c_cubic); end
    endtask

    task automatic test_illegal_read();
        logic [7:0] addrs [3];
        addrs = '{8'h00, 8'h03, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1;
            rd_addr = addrs[i];
            step();
            checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL illegal_valid[%0d]: got %b expected 1", i, valid1); end
            checks++; if (eff1 !== 1'b0)   begin errors++; $display("FAIL illegal_eff[%0d]: got %b expected 0", i, eff1); end
            checks++; if (out1 !== '0)    begin errors++; $display("FAIL illegal_out[%0d]: got %h expected 0", i, out1); end
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_user_write();
        wr_en = 1'b1; wr_addr = 8'd32; wr_data = W'(12'hABC);
        step();
        wr_en = 1'b0;
        checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL user_wr_err: got %b expected 0", err1); end
        rd_en = 1'b1; rd_addr = 8'd32;
        step();
        rd_en = 1'b0;
        checks++; if (out1 !== W'(12'hABC)) begin errors++; $display("FAIL user_rd_out: got %h expected abc", out1); end
        checks++; if (eff1 !== 1'b1)        begin errors++; $display("FAIL user_rd_eff: got %b expected 1", eff1); end
    endtask

    task automatic test_const_write();
        wr_en = 1'b1; wr_addr = 8'd4; wr_data = '1;
        step();
        wr_en = 1'b0;
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL const_wr_err1: got %b expected 1", err1); end
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL const_wr_err3: got %b expected 1", err3); end
        rd_en = 1'b1; rd_addr = 8'd4;
        step();
        rd_en = 1'b0;
        checks++; if (err1 !== 1'b0)    begin errors++; $display("FAIL const_wr_err_clear: got %b expected 0", err1); end
        checks++; if (out1 !== c_plus) begin errors++; $display("FAIL const_wr_readback: got %h expected %h", out1, c_plus); end
        // Multi-hot write spanning two user slots must be rejected and change nothing.
        wr_en = 1'b1; wr_addr = 8'h60; wr_data = W'(16'hDEAD);
        step();
        wr_en = 1'b0;
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL multihot_wr_err: got %b expected 1", err1); end
        rd_en = 1'b1; rd_addr = 8'd32;
        step();
        rd_en = 1'b0;
        checks++; if (out1 !== W'(12'hABC)) begin errors++; $display("FAIL multihot_slot_kept: got %h expected abc", out1); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 8'd64; wr_data = W'(12'h123);
        rd_en = 1'b1; rd_addr = 8'd64;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (out1 !== W'(12'h123)) begin errors++; $display("FAIL bypass_out: got %h expected 123", out1); end
        checks++; if (eff1 !== 1'b1)        begin errors++; $display("FAIL bypass_eff: got %b expected 1", eff1); end
        idle(4);
        rd_en = 1'b1; rd_addr = 8'd128;
        step();
        wr_en = 1'b1; wr_addr = 8'd128; wr_data = W'(12'h777);
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (out1 !== W'(12'h777)) begin errors++; $display("FAIL bypass_l1_new: got %h expected 777", out1); end
        step();
        checks++; if (valid3 !== 1'b1) begin errors++; $display("FAIL inflight_valid: got %b expected 1", valid3); end
        checks++; if (out3 !== '0)    begin errors++; $display("FAIL inflight_old: got %h expected 0", out3); end
        step();
        checks++; if (out3 !== W'(12'h777)) begin errors++; $display("FAIL inflight_new: got %h expected 777", out3); end
    endtask

    task automatic test_latency3();
        logic         exp_v [6];
        logic [W-1:0] exp_o [6];
        idle(4);
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_o = '{W'(12'h777), W'(12'h777), W'(1), W'(1), c_plus, c_plus};
        for (int i = 0; i < 6; i++) begin
            rd_en = (i == 0) || (i == 2);
            rd_addr = (i == 0) ? 8'd2 : 8'd4;
            step();
            checks++; if (valid3 !== exp_v[i]) begin errors++; $display("FAIL lat3_valid[%0d]: got %b expected %b", i, valid3, exp_v[i]); end
            checks++; if (out3 !== exp_o[i])  begin errors++; $display("FAIL lat3_out[%0d]: got %h expected %h", i, out3, exp_o[i]); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        idle(4);
        rd_en = 1'b1; rd_addr = 8'd32;
        step();
        step();
        reset = 1'b1;
        #1;
        checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b expected 0", valid3); end
        checks++; if (out3 !== '0)    begin errors++; $display("FAIL midrst_async_out: got %h expected 0", out3); end
        step();
        reset = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL midrst_drop[%0d]: got %b expected 0", i, valid3); end
        end
        rd_en = 1'b1; rd_addr = 8'd32;
        step();
        rd_en = 1'b0;
        checks++; if (out1 !== '0)    begin errors++; $display("FAIL midrst_slot_l1: got %h expected 0", out1); end
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL midrst_valid_l1: got %b expected 1", valid1); end
        step();
        checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL midrst_early_l3: got %b expected 0", valid3); end
        step();
        checks++; if (valid3 !== 1'b1) begin errors++; $display("FAIL midrst_valid_l3: got %b expected 1", valid3); end
        checks++; if (eff3 !== 1'b1)   begin errors++; $display("FAIL midrst_eff_l3: got %b expected 1", eff3); end
        checks++; if (out3 !== '0)    begin errors++; $display("FAIL midrst_slot_l3: got %h expected 0", out3); end
    endtask

    initial begin
        c_plus  = W'(6'h05) << (W - 6);
        c_minus = W'(6'h09) << (W - 6);
        c_cubic = W'(6'h15) << (W - 6);
        test_reset();
        test_constants();
        test_illegal_read();
        test_user_write();
        test_const_write();
        test_bypass();
        test_latency3();
        test_mid_reset();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/const_bank.md
Name: const_bank

Overview:
- Parametrised, pipelined constant and user-register bank serving the pairing datapath's operand mux.
- Each read supplies a WIDTH-bit operand selected by a one-hot address.
- The five hardwired constants (0, 1, +, -, cubic) sit in the low address bits.
- Address bits above those select software-loadable user slots, written through a separate write port.
- Reads are fully pipelined with configurable latency, a valid strobe, and a hit flag ("effective").

Parameters:
- WIDTH, 198: operand width in bits. Must be ≥ 6.
- ADDR_W, 8: one-hot address width. Bits 0..4 are fixed constants; bits 5..ADDR_W-1 are user slots. Must be ≥ 5.
- LATENCY, 1: read latency in cycles, legal range 1..4.
- NUM_USER, ADDR_W-5: derived localparam, the number of user slots.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- rd_en  input  1  read request; one accepted every cycle, no backpressure.
- rd_addr  input  ADDR_W  one-hot read address.
- wr_en  input  1  user-slot write strobe.
- wr_addr  input  ADDR_W  one-hot write address.
- wr_data  input  WIDTH  write data.
- out  output  WIDTH  read data.
- out_valid  output  1  out and effective correspond to a read issued LATENCY cycles earlier.
- effective  output  1  high if the read address was a legal one-hot hit.
- wr_err  output  1  one-cycle pulse: the last write was rejected.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out=0, out_valid=0, effective=0, wr_err=0.
  - All user slots cleared to 0.
  - All pipeline stages are invalidated; reads in flight are dropped and never produce out_valid.
- Read decode, stage 0, on the clk edge where rd_en=1:
  - addr=1 → 0.
  - addr=2 → 1.
  - addr=4 → {6'b000101, (WIDTH-6) zeros}.
  - addr=8 → {6'b001001, zeros}.
  - addr=16 → {6'b010101, zeros}.
  - addr=1<<(5+k), k<NUM_USER → user slot k.
  - Any other value (zero, multi-hot) → data 0, effective=0.
- Pipeline:
  - The decoded {data, effective, valid} passes through LATENCY register stages.
  - out_valid=1 exactly LATENCY cycles after the rd_en edge.
  - rd_en=0 → a bubble. out_valid=0 and out/effective hold their previous values.
  - Back-to-back reads give back-to-back results in issue order.
- Write:
  - On the clk edge with wr_en=1 and wr_addr a one-hot user-slot address, the slot loads wr_data.
  - wr_addr hitting a fixed-constant bit, zero, or multi-hot → no state change, and wr_err=1 for the following cycle.
  - wr_err=0 otherwise.
- Simultaneous read and write to the same slot on the same edge: the read returns the NEW data (write-through bypass in stage 0).
  - Reads issued earlier and still in the pipe keep the old data.
- Simultaneous read and write to different slots: independent.
- Fixed constants are never modifiable.
- No internal FSM beyond the valid pipeline; throughput is 1 read/cycle plus 1 write/cycle.

Test Plan:
- Default params, LATENCY=1; reads at addr 1, 2, 4, 8, 16 on consecutive cycles:
  - out_valid high for 5 consecutive cycles starting 1 cycle after the first read.
  - out = 0, 1, 0x05<<192, 0x09<<192, 0x15<<192.
  - effective=1 throughout.
- Reads at addr 0, 3, 0xFF → out=0, effective=0, out_valid=1 for each.
- Write 0xABC to addr 32, then read addr 32 → out=0xABC, effective=1.
- Write to addr 4 → wr_err pulses 1 cycle; a subsequent read at addr 4 still returns 0x05<<192.
- Same-edge write 0x123 and read at addr 64 → out=0x123.
- LATENCY=3, read stream 2,_,4 with rd_en low in the middle cycle:
  - out_valid pattern 1,0,1 starting 3 cycles after the first read.
  - out holds 1 during the bubble.
- Mid-stream reset: issue 3 reads with LATENCY=3, assert reset after the 2nd read.
  - out_valid stays 0 until new reads arrive.
  - User slot 32 reads back 0.
